// File: rtl/wb_queue_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// wb_queue_pkg : core defines for the writeback queue. Rev 1.0
// ---------------------------------------------------------------------
package wb_queue_pkg;

    localparam int WB_NUM_W  = 5;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_NUM_W-1:0]  num;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : wb_queue_pkg
`default_nettype wire

// File: rtl/wb_queue_ram.sv
`default_nettype none
// ---------------------------------------------------------------------
// wb_queue_ram : DEPTH x W entry store, 2 write ports, 2 async reads. Rev 1.0
// ---------------------------------------------------------------------
module wb_queue_ram
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = WB_NUM_W + WB_DATA_W
) (
    input  logic                     clk,
    input  logic                     we0_i,
    input  logic [$clog2(DEPTH)-1:0] waddr0_i,
    input  logic [W-1:0]             wdata0_i,
    input  logic                     we1_i,
    input  logic [$clog2(DEPTH)-1:0] waddr1_i,
    input  logic [W-1:0]             wdata1_i,
    input  logic [$clog2(DEPTH)-1:0] raddr0_i,
    output logic [W-1:0]             rdata0_o,
    input  logic [$clog2(DEPTH)-1:0] raddr1_i,
    output logic [W-1:0]             rdata1_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write addresses are always tail and tail+1, so they never collide.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule : wb_queue_ram
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ---------------------------------------------------------------------
// wb_queue : dual-issue writeback queue feeding two register-file ports. Rev 1.0
// ---------------------------------------------------------------------
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = WB_DATA_W,
    parameter int NUM_W  = WB_NUM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in0_valid,
    input  logic [NUM_W-1:0]           in0_num,
    input  logic [DATA_W-1:0]          in0_data,
    input  logic                       in1_valid,
    input  logic [NUM_W-1:0]           in1_num,
    input  logic [DATA_W-1:0]          in1_data,
    output logic                       in_ready,
    input  logic                       drain_en,
    input  logic                       flush,
    output logic                       pba_we,
    output logic [NUM_W-1:0]           pba_num,
    output logic [DATA_W-1:0]          pba_data,
    output logic                       wb_we,
    output logic [NUM_W-1:0]           wb_num,
    output logic [DATA_W-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = NUM_W + DATA_W;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pba_we_q, wb_we_q, ovf_err_q, ovf_err_d;
    logic [NUM_W-1:0]  pba_num_q, wb_num_q;
    logic [DATA_W-1:0] pba_data_q, wb_data_q;

    logic              qual0, qual1, accept;
    logic [1:0]        enq_n, deq_n;
    logic              ram_we0, ram_we1;
    logic [ENT_W-1:0]  ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;

    // Ready depends on registered occupancy only.
    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

    always_comb begin
        qual0     = in0_valid && (in0_num != '0);
        qual1     = in1_valid && (in1_num != '0);
        accept    = in_ready && !flush;
        enq_n     = accept ? ({1'b0, qual0} + {1'b0, qual1}) : 2'd0;
        deq_n     = 2'd0;
        if (drain_en && !flush)
            deq_n = (count_q > CNT_W'(1)) ? 2'd2 : count_q[1:0];
        ovf_err_d = ovf_err_q || (!in_ready && (in0_valid || in1_valid));
        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
            head_d  = head_q + PTR_W'(deq_n);
            tail_d  = tail_q + PTR_W'(enq_n);
        end
    end

    // A lone in1 compacts into the tail slot.
    assign ram_we0    = (enq_n != 2'd0);
    assign ram_we1    = (enq_n == 2'd2);
    assign ram_wdata0 = qual0 ? {in0_num, in0_data} : {in1_num, in1_data};
    assign ram_wdata1 = {in1_num, in1_data};

    wb_queue_ram #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_ram (
        .clk      (clk),
        .we0_i    (ram_we0),
        .waddr0_i (tail_q),
        .wdata0_i (ram_wdata0),
        .we1_i    (ram_we1),
        .waddr1_i (tail_q + PTR_W'(1)),
        .wdata1_i (ram_wdata1),
        .raddr0_i (head_q),
        .rdata0_o (ram_rdata0),
        .raddr1_i (head_q + PTR_W'(1)),
        .rdata1_o (ram_rdata1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_err_q  <= 1'b0;
            pba_we_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            pba_num_q  <= '0;
            pba_data_q <= '0;
            wb_num_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ovf_err_q <= ovf_err_d;
            pba_we_q  <= (deq_n != 2'd0);
            wb_we_q   <= (deq_n == 2'd2);
            if (deq_n != 2'd0) begin
                pba_num_q  <= ram_rdata0[ENT_W-1 -: NUM_W];
                pba_data_q <= ram_rdata0[DATA_W-1:0];
            end
            if (deq_n == 2'd2) begin
                wb_num_q  <= ram_rdata1[ENT_W-1 -: NUM_W];
                wb_data_q <= ram_rdata1[DATA_W-1:0];
            end
        end
    end

    assign pba_we   = pba_we_q;
    assign pba_num  = pba_num_q;
    assign pba_data = pba_data_q;
    assign wb_we    = wb_we_q;
    assign wb_num   = wb_num_q;
    assign wb_data  = wb_data_q;
    assign count    = count_q;
    assign ovf_err  = ovf_err_q;

endmodule : wb_queue
`default_nettype wire
